affine_2_inv_serial: RTL
========================

AFFINE_2_INV_SERIAL -- requirements
Module: affine_2_inv_serial

Interface
REQ-001 SHALL have parameter LANES, default 1, giving nibbles transformed per share per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: a 3-share state is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a state this cycle.
REQ-006 SHALL have ports x1, x2, x3, input, 64 bits each: Boolean shares of the input state; nibble i occupies bits [4i+3:4i].
REQ-007 SHALL have port out_valid, output, 1 bit: y1..y3 hold a finished result.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-009 SHALL have ports y1, y2, y3, output, 64 bits each: output shares.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL compute each nibble of y_k as A2_INV_LUT[x_k nibble], share-wise, for k = 1..3; A2_INV_LUT is the inverse of the PRINCE TI A2 affine layer.
REQ-012 SHALL never combine bits of different shares in any logic cone or register (non-completeness is preserved).
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; in_ready = (state == IDLE) and out_valid = (state == DONE).
REQ-014 In IDLE, in_valid && in_ready SHALL load x1..x3 into the three 64-bit share registers, clear the cycle counter and enter RUN.
REQ-015 Each RUN cycle SHALL, per share, transform the LANES least-significant nibbles, rotate the register right by 4*LANES bits with the transformed nibbles entering at the top, and increment the counter.
REQ-016 After exactly N = 16/LANES RUN cycles, every nibble SHALL be back in its original position; the FSM then enters DONE.
REQ-017 out_valid SHALL first be high exactly N+1 rising edges after the accepting edge (17 for LANES=1).
REQ-018 In DONE, y1..y3 SHALL equal the share registers and SHALL stay stable while out_ready is low.
REQ-019 In DONE with out_ready high, the FSM SHALL return to IDLE at the next edge; a new state cannot be accepted in that same cycle.
REQ-020 in_valid SHALL be ignored outside IDLE; no input is buffered or dropped silently, because in_ready is low.
REQ-021 The counter SHALL be ceil(log2(N))+1 bits wide and SHALL NOT wrap during RUN.

Reset
REQ-022 While rst is high, the block SHALL set state = IDLE, counter = 0 and all share registers = 0 (so y1..y3 = 0), and hold out_valid = 0, in_ready = 0 and busy = 0.
REQ-023 Reset asserted in RUN or DONE SHALL abort the operation, discard the result and never raise out_valid for that state.
REQ-024 in_ready SHALL go high in the first cycle after rst deasserts.

Structure
REQ-025 Package prince_ti_pkg SHALL hold A2_INV_LUT (16 x 4-bit), NIBBLES = 16 and the FSM state enum.
REQ-026 Sub-module affine_2_inv_nibble (4-bit, combinational, single share) SHALL be instantiated 3*LANES times, one per share per lane.
REQ-027 The implementation SHALL be 120-400 lines of RTL in total.

Verification
REQ-028 Test: all shares = 0, LANES=1 -> every nibble of y1..y3 = A2_INV_LUT[0], and out_valid rises 17 edges after the handshake.
REQ-029 Test: random x, each share passed through the forward A2 model and fed in -> y_k == x_k for all k, checked over 1000 vectors.
REQ-030 Test: y1^y2^y3 per nibble == A2_INV_LUT[(x1^x2^x3) nibble] for random, non-uniform shares.
REQ-031 Test: out_ready held low for 5 cycles in DONE -> y stable, in_ready = 0, busy = 1; IDLE is reached one edge after out_ready = 1.
REQ-032 Test: rst pulsed on RUN cycle 7 -> out_valid never asserts, y = 0, and in_ready = 1 in the cycle after release.
REQ-033 Test: LANES=4 with the stimulus of REQ-028 -> identical result, with out_valid rising 5 edges after the handshake.

Source files
------------

// File: rtl/prince_ti_pkg.sv
// Shared constants for the threshold-implementation PRINCE inverse A2 layer:
// the nibble lookup table, the nibble count of a 64-bit state and the FSM states.
package prince_ti_pkg;

  // Number of 4-bit nibbles in one 64-bit share.
  localparam int NIBBLES = 16;

  // Inverse A2 affine layer, entry i at index i (index 15 is written first).
  // The mapping is affine (y = M*x ^ 4'h6), so it commutes with XOR sharing.
  localparam logic [15:0][3:0] A2_INV_LUT = {
    4'hE, 4'hF, 4'hD, 4'hC, 4'h8, 4'h9, 4'hB, 4'hA,
    4'h2, 4'h3, 4'h1, 4'h0, 4'h4, 4'h5, 4'h7, 4'h6
  };

  // Controller states of the serial transformer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/affine_2_inv_nibble.sv
// One nibble of one share through the inverse A2 affine layer (pure combinational).
module affine_2_inv_nibble
  import prince_ti_pkg::*;
(
  input  logic [3:0] x,
  output logic [3:0] y
);

  assign y = A2_INV_LUT[x];

endmodule

// File: rtl/affine_2_inv_serial.sv
// Serial, share-wise inverse A2 layer for a 3-share PRINCE state.
// LANES nibbles of every share are transformed per cycle while each share
// register rotates right, so after 16/LANES RUN cycles every nibble is back home.
// The three shares never meet in any cone of logic.
module affine_2_inv_serial
  import prince_ti_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] x1,
  input  logic [63:0] x2,
  input  logic [63:0] x3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] y1,
  output logic [63:0] y2,
  output logic [63:0] y3,
  output logic        busy
);

  localparam int N  = NIBBLES / LANES;
  localparam int CW = $clog2(N) + 1;
  localparam int SW = 4 * LANES;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [63:0]   sh1;
  logic [63:0]   sh2;
  logic [63:0]   sh3;
  logic [SW-1:0] t1;
  logic [SW-1:0] t2;
  logic [SW-1:0] t3;
  logic [63:0]   rot1;
  logic [63:0]   rot2;
  logic [63:0]   rot3;
  logic          run_last;
  logic          accept;

  // One lookup per lane per share on the least-significant nibbles.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    affine_2_inv_nibble u_s1 (.x(sh1[4*l +: 4]), .y(t1[4*l +: 4]));
    affine_2_inv_nibble u_s2 (.x(sh2[4*l +: 4]), .y(t2[4*l +: 4]));
    affine_2_inv_nibble u_s3 (.x(sh3[4*l +: 4]), .y(t3[4*l +: 4]));
  end

  // Rotate right by SW bits with the transformed nibbles entering at the top.
  if (LANES == NIBBLES) begin : g_rot_full
    assign rot1 = t1;
    assign rot2 = t2;
    assign rot3 = t3;
  end else begin : g_rot_part
    assign rot1 = {t1, sh1[63:SW]};
    assign rot2 = {t2, sh2[63:SW]};
    assign rot3 = {t3, sh3[63:SW]};
  end

  // The counter reaches N after the last transforming cycle; that cycle moves to DONE.
  assign run_last = (cnt == CW'(N));
  assign accept   = (state == IDLE) && in_valid && !rst;

  // Next-state logic of the IDLE/RUN/DONE controller.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (run_last) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Controller state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Share registers and cycle counter: load on accept, transform/rotate in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh1 <= 64'd0;
      sh2 <= 64'd0;
      sh3 <= 64'd0;
      cnt <= '0;
    end else if (accept) begin
      sh1 <= x1;
      sh2 <= x2;
      sh3 <= x3;
      cnt <= '0;
    end else if ((state == RUN) && !run_last) begin
      sh1 <= rot1;
      sh2 <= rot2;
      sh3 <= rot3;
      cnt <= cnt + CW'(1);
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE) && !rst;
  assign busy      = (state != IDLE) && !rst;
  assign y1        = sh1;
  assign y2        = sh2;
  assign y3        = sh3;

endmodule
